// File: rtl/aram_dual_port.sv
// Dual-port synchronous audio RAM.
// Port A (SPC700 core) reads and writes; port B (DSP sample fetch) only reads.
// When CLEAR_ON_RST is set, a clear engine writes CLEAR_VALUE to every address
// after reset, and both ports are locked out while it runs.
//
// Handshake: a request on a port is accepted at a rising edge when its enable is
// high and busy is low. a_ready equals !busy. An accepted read updates rdata at
// that edge and raises rvalid for exactly the following cycle. rvalid is low in
// every cycle that follows an edge with no accepted read, and rdata then holds.
module aram_dual_port #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter bit                    CLEAR_ON_RST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
  parameter bit                    RDW_MODE     = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  output logic                  a_ready,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  busy
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clear_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    a_rd;
  logic                    b_rd;
  logic                    b_hit;

  // Busy and ready are decoded straight from the state register.
  assign busy    = (state == ST_CLEAR);
  assign a_ready = ~busy;

  // Select the single write source (the clear engine or port A) and qualify reads.
  // A reset edge never writes, so reset leaves the contents alone.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = a_addr;
    mem_wdata = a_wdata;
    if (reset_n) begin
      if (busy) begin
        mem_we    = 1'b1;
        mem_waddr = clear_addr;
        mem_wdata = CLEAR_VALUE;
      end else if (a_en && a_we) begin
        mem_we = 1'b1;
      end
    end
    a_rd  = ~busy & a_en & ~a_we;
    b_rd  = ~busy & b_en;
    b_hit = ~busy & a_en & a_we & (a_addr == b_addr);
  end

  // Memory array write port. It has no reset, so it maps onto a plain RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM, clear address counter and registered read outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      clear_addr <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) begin
        a_rdata <= mem[a_addr];
      end
      if (b_rd) begin
        // The array read returns the old word. Write-through forwards port A data instead.
        b_rdata <= (RDW_MODE && b_hit) ? a_wdata : mem[b_addr];
      end
      case (state)
        ST_CLEAR: begin
          clear_addr <= clear_addr + 1'b1;
          if (clear_addr == LAST_ADDR) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
